// File: rtl/z80_counted_branch_unit_if.sv
// z80_counted_branch_unit_if
//
// Purpose: bundles the request, displacement-read and result signals of the
// counted branch unit so the core sequencer and the unit share one port.
//
// Parameter:
//   CNT_W    counter width; must match the unit it is connected to
//
// Signals:
//   start, ip_in, cnt_in, cond   operation request from the sequencer
//   busy, done                   unit status / one-clock completion pulse
//   rd_req, rd_addr              displacement read request and address
//   rd_ack, rd_data              read completion and displacement byte
//   mcycle                       current M-cycle type (0 none, 1 M1, 2 read, 3 internal)
//   taken, ip_out, cnt_out       branch results, written back on done
//
// Modports:
//   master   sequencer / memory side
//   slave    the counted branch unit
interface z80_counted_branch_unit_if #(
    parameter int CNT_W = 8
) ();
    logic             start;
    logic [15:0]      ip_in;
    logic [CNT_W-1:0] cnt_in;
    logic             cond;
    logic             busy;
    logic             rd_req;
    logic [15:0]      rd_addr;
    logic             rd_ack;
    logic [7:0]       rd_data;
    logic [1:0]       mcycle;
    logic             done;
    logic             taken;
    logic [15:0]      ip_out;
    logic [CNT_W-1:0] cnt_out;

    modport master (
        output start, ip_in, cnt_in, cond, rd_ack, rd_data,
        input  busy, rd_req, rd_addr, mcycle, done, taken, ip_out, cnt_out
    );

    modport slave (
        input  start, ip_in, cnt_in, cond, rd_ack, rd_data,
        output busy, rd_req, rd_addr, mcycle, done, taken, ip_out, cnt_out
    );
endinterface

// File: rtl/z80_counted_branch_unit.sv
// z80_counted_branch_unit
//
// Purpose: executes a DJNZ-style counted relative branch. On start it latches
// IP, counter and condition, fetches the signed displacement through a
// read handshake, decrements the counter and computes the next IP.
//
// Parameters:
//   CNT_W     counter width (8 = B, 16 = BC)
//   INSN_LEN  instruction length in bytes including the displacement, 2..4
//
// Ports:
//   clk      clock, one clock per T-state
//   reset    synchronous active-high reset
//   bus      z80_counted_branch_unit_if.slave (request, read handshake, results)
//
// Configuration macro:
//   Z80_CBU_TCYCLE_EN  when defined, the unit is T-state accurate: an extra M1
//                      clock, a read cycle of at least 3 clocks and a 5-clock
//                      internal cycle when the branch is taken. When undefined,
//                      M1X is skipped, the read ends on rd_ack and the internal
//                      cycle is a single clock. Results are identical.
module z80_counted_branch_unit #(
    parameter int CNT_W    = 8,
    parameter int INSN_LEN = 2
) (
    input logic                     clk,
    input logic                     reset,
    z80_counted_branch_unit_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        M1X,
        RD,
        INT,
        DONE
    } state_t;

    state_t state, state_next;

    logic [15:0]      ip_lat;
    logic [CNT_W-1:0] cnt_lat;
    logic             cond_lat;
    logic [7:0]       disp;
    logic [CNT_W-1:0] cnt_dec;
    logic             branch_taken;
    logic             rd_exit;
    logic             disp_capture;
    logic [15:0]      ip_target;

`ifdef Z80_CBU_TCYCLE_EN
    logic [1:0] rd_cycles;
    logic       got_ack;
    logic [2:0] int_cycles;
`endif

    // The branch decision depends only on latched operands, so it is stable
    // for the whole operation and can steer both RD exit and the IP update.
    assign cnt_dec      = cnt_lat - CNT_W'(1);
    assign branch_taken = (cnt_dec != '0) && cond_lat;
    assign ip_target    = ip_lat + 16'(INSN_LEN)
                        + (branch_taken ? {{8{disp[7]}}, disp} : 16'h0000);

`ifdef Z80_CBU_TCYCLE_EN
    // Read cycle is padded to three clocks; an early ack is remembered so a
    // later spurious rd_ack cannot recapture the displacement.
    assign rd_exit      = (got_ack || bus.rd_ack) && (rd_cycles == 2'd2);
    assign disp_capture = (state == RD) && bus.rd_ack && !got_ack;
`else
    assign rd_exit      = bus.rd_ack;
    assign disp_capture = (state == RD) && bus.rd_ack;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        bus.busy   = 1'b0;
        bus.rd_req = 1'b0;
        bus.mcycle = 2'd0;
        bus.done   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
`ifdef Z80_CBU_TCYCLE_EN
                    state_next = M1X;
`else
                    state_next = RD;
`endif
                end
            end
            M1X: begin
                bus.busy   = 1'b1;
                bus.mcycle = 2'd1;
                state_next = RD;
            end
            RD: begin
                bus.busy   = 1'b1;
                bus.mcycle = 2'd2;
`ifdef Z80_CBU_TCYCLE_EN
                bus.rd_req = !got_ack;
`else
                bus.rd_req = 1'b1;
`endif
                if (rd_exit) begin
                    state_next = branch_taken ? INT : DONE;
                end
            end
            INT: begin
                bus.busy   = 1'b1;
                bus.mcycle = 2'd3;
`ifdef Z80_CBU_TCYCLE_EN
                if (int_cycles == 3'd4) begin
                    state_next = DONE;
                end
`else
                state_next = DONE;
`endif
            end
            DONE: begin
                bus.busy   = 1'b1;
                bus.done   = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand latches and result registers. Results keep their value until
    // the next operation overwrites them; reset clears everything so an
    // aborted operation leaves no partial writeback.
    always_ff @(posedge clk) begin
        if (reset) begin
            ip_lat      <= 16'h0000;
            cnt_lat     <= '0;
            cond_lat    <= 1'b0;
            disp        <= 8'h00;
            bus.rd_addr <= 16'h0000;
            bus.ip_out  <= 16'h0000;
            bus.cnt_out <= '0;
            bus.taken   <= 1'b0;
        end else begin
            if (state == IDLE && bus.start) begin
                ip_lat      <= bus.ip_in;
                cnt_lat     <= bus.cnt_in;
                cond_lat    <= bus.cond;
                bus.rd_addr <= bus.ip_in + 16'(INSN_LEN - 1);
            end
            if (disp_capture) begin
                disp <= bus.rd_data;
            end
            if (state == RD && rd_exit) begin
                bus.cnt_out <= cnt_dec;
                bus.taken   <= branch_taken;
            end
            if (state_next == DONE && state != DONE) begin
                bus.ip_out <= ip_target;
            end
        end
    end

`ifdef Z80_CBU_TCYCLE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_cycles  <= 2'd0;
            got_ack    <= 1'b0;
            int_cycles <= 3'd0;
        end else begin
            if (state != RD) begin
                rd_cycles <= 2'd0;
                got_ack   <= 1'b0;
            end else begin
                if (rd_cycles != 2'd2) begin
                    rd_cycles <= rd_cycles + 2'd1;
                end
                if (bus.rd_ack) begin
                    got_ack <= 1'b1;
                end
            end
            if (state != INT) begin
                int_cycles <= 3'd0;
            end else begin
                int_cycles <= int_cycles + 3'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_z80_counted_branch_unit.sv
// tb_z80_counted_branch_unit
//
// Purpose: self-checking bench for z80_counted_branch_unit. Three instances
// (CNT_W/INSN_LEN = 8/2, 16/2, 8/3) receive the same stimulus; each result is
// compared with a behavioural model, and the table vectors are also compared
// against hand-derived constants. Timing expectations follow the
// Z80_CBU_TCYCLE_EN macro when it is defined for the bench.
module tb_z80_counted_branch_unit;

`ifdef Z80_CBU_TCYCLE_EN
    localparam bit TCYC = 1'b1;
`else
    localparam bit TCYC = 1'b0;
`endif

    localparam int DUT_CW [3] = '{8, 16, 8};
    localparam int DUT_IL [3] = '{2, 2, 3};

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] ip_in;
    logic [15:0] cnt_in;
    logic        cond_in;
    logic        rd_ack;
    logic [7:0]  rd_data;

    always #5 clk = ~clk;

    z80_counted_branch_unit_if #(.CNT_W(8))  bus_a ();
    z80_counted_branch_unit_if #(.CNT_W(16)) bus_b ();
    z80_counted_branch_unit_if #(.CNT_W(8))  bus_c ();

    assign bus_a.start   = start;
    assign bus_a.ip_in   = ip_in;
    assign bus_a.cnt_in  = cnt_in[7:0];
    assign bus_a.cond    = cond_in;
    assign bus_a.rd_ack  = rd_ack;
    assign bus_a.rd_data = rd_data;
    assign bus_b.start   = start;
    assign bus_b.ip_in   = ip_in;
    assign bus_b.cnt_in  = cnt_in;
    assign bus_b.cond    = cond_in;
    assign bus_b.rd_ack  = rd_ack;
    assign bus_b.rd_data = rd_data;
    assign bus_c.start   = start;
    assign bus_c.ip_in   = ip_in;
    assign bus_c.cnt_in  = cnt_in[7:0];
    assign bus_c.cond    = cond_in;
    assign bus_c.rd_ack  = rd_ack;
    assign bus_c.rd_data = rd_data;

    z80_counted_branch_unit #(.CNT_W(8),  .INSN_LEN(2)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    z80_counted_branch_unit #(.CNT_W(16), .INSN_LEN(2)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));
    z80_counted_branch_unit #(.CNT_W(8),  .INSN_LEN(3)) dut_c (.clk(clk), .reset(reset), .bus(bus_c));

    logic        o_busy [3];
    logic        o_req  [3];
    logic        o_done [3];
    logic        o_taken[3];
    logic [1:0]  o_mc   [3];
    logic [15:0] o_addr [3];
    logic [15:0] o_cnt  [3];
    logic [15:0] o_ip   [3];

    assign o_busy[0]  = bus_a.busy;
    assign o_busy[1]  = bus_b.busy;
    assign o_busy[2]  = bus_c.busy;
    assign o_req[0]   = bus_a.rd_req;
    assign o_req[1]   = bus_b.rd_req;
    assign o_req[2]   = bus_c.rd_req;
    assign o_done[0]  = bus_a.done;
    assign o_done[1]  = bus_b.done;
    assign o_done[2]  = bus_c.done;
    assign o_taken[0] = bus_a.taken;
    assign o_taken[1] = bus_b.taken;
    assign o_taken[2] = bus_c.taken;
    assign o_mc[0]    = bus_a.mcycle;
    assign o_mc[1]    = bus_b.mcycle;
    assign o_mc[2]    = bus_c.mcycle;
    assign o_addr[0]  = bus_a.rd_addr;
    assign o_addr[1]  = bus_b.rd_addr;
    assign o_addr[2]  = bus_c.rd_addr;
    assign o_cnt[0]   = {8'h00, bus_a.cnt_out};
    assign o_cnt[1]   = bus_b.cnt_out;
    assign o_cnt[2]   = {8'h00, bus_c.cnt_out};
    assign o_ip[0]    = bus_a.ip_out;
    assign o_ip[1]    = bus_b.ip_out;
    assign o_ip[2]    = bus_c.ip_out;

    typedef struct {
        int          dut;
        logic [15:0] ip;
        logic [15:0] cnt;
        logic        cnd;
        logic [7:0]  data;
        int          delay;
        logic [15:0] e_addr;
        logic [15:0] e_cnt;
        logic        e_taken;
        logic [15:0] e_ip;
        int          e_done_on;
        int          e_done_off;
    } vec_t;

    vec_t vecs[6];

    int checks = 0;
    int errors = 0;
    int done_cyc[3];
    int done_cnt[3];
    int busy_cnt[3];
    int m1_cnt[3];
    int rd_cnt[3];
    int int_cnt[3];
    int req_cnt[3];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: counter, address and target from plain modular arithmetic.
    function automatic void model(input int cw, input int il, input logic [15:0] ip,
                                  input logic [15:0] cnt, input logic cnd, input logic [7:0] d,
                                  output logic [15:0] e_addr, output logic [15:0] e_cnt,
                                  output logic e_taken, output logic [15:0] e_ip);
        int mask;
        int c;
        int disp;
        mask    = (1 << cw) - 1;
        c       = int'(cnt) & mask;
        c       = (c + mask) % (mask + 1);
        e_cnt   = 16'(c);
        e_taken = (c != 0) && cnd;
        e_addr  = 16'((int'(ip) + il - 1) % 65536);
        disp    = (d >= 8'd128) ? int'(d) - 256 : int'(d);
        e_ip    = 16'((int'(ip) + il + (e_taken ? disp : 0) + 65536) % 65536);
    endfunction

    function automatic int rdLen(input int delay);
        if (TCYC) return (delay + 1 > 3) ? delay + 1 : 3;
        return delay + 1;
    endfunction

    function automatic int expDone(input int delay, input logic tk);
        return (TCYC ? 1 : 0) + rdLen(delay) + (tk ? (TCYC ? 5 : 1) : 0) + 1;
    endfunction

    // Drives one operation into all three units and acts as the memory:
    // rd_ack follows rd_req after `delay` clocks; while rd_req is low the
    // memory toggles rd_ack/rd_data randomly, which the units must ignore.
    task automatic applyStimulus(input logic [15:0] ip, input logic [15:0] cnt, input logic cnd,
                                 input logic [7:0] data, input int delay, input string tag);
        int reqs;
        reqs = 0;
        for (int d = 0; d < 3; d++) begin
            done_cyc[d] = -1;
            done_cnt[d] = 0;
            busy_cnt[d] = 0;
            m1_cnt[d]   = 0;
            rd_cnt[d]   = 0;
            int_cnt[d]  = 0;
            req_cnt[d]  = 0;
        end
        @(posedge clk);
        #1;
        start   = 1'b1;
        ip_in   = ip;
        cnt_in  = cnt;
        cond_in = cnd;
        rd_ack  = 1'b0;
        rd_data = 8'($urandom);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checkOutput($sformatf("%s dut%0d cycle0 busy", tag, d), 32'(o_busy[d]), 32'd0);
        end
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (o_req[0]) begin
                rd_ack  = (reqs == delay);
                rd_data = rd_ack ? data : 8'($urandom);
                reqs++;
            end else begin
                rd_ack  = 1'($urandom_range(0, 1));
                rd_data = 8'($urandom);
            end
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (o_busy[d]) busy_cnt[d]++;
                if (o_req[d]) req_cnt[d]++;
                if (o_mc[d] == 2'd1) m1_cnt[d]++;
                if (o_mc[d] == 2'd2) rd_cnt[d]++;
                if (o_mc[d] == 2'd3) int_cnt[d]++;
                if (o_done[d]) begin
                    done_cnt[d]++;
                    if (done_cyc[d] < 0) done_cyc[d] = c;
                end
            end
            if (done_cyc[0] >= 0 && done_cyc[1] >= 0 && done_cyc[2] >= 0) break;
        end
        rd_ack = 1'b0;
    endtask

    task automatic checkModel(input int d, input logic [15:0] ip, input logic [15:0] cnt,
                              input logic cnd, input logic [7:0] data, input int delay,
                              input string tag);
        logic [15:0] e_addr;
        logic [15:0] e_cnt;
        logic        e_taken;
        logic [15:0] e_ip;
        string       n;
        model(DUT_CW[d], DUT_IL[d], ip, cnt, cnd, data, e_addr, e_cnt, e_taken, e_ip);
        n = $sformatf("%s dut%0d", tag, d);
        checkOutput({n, " rd_addr"}, 32'(o_addr[d]), 32'(e_addr));
        checkOutput({n, " cnt_out"}, 32'(o_cnt[d]), 32'(e_cnt));
        checkOutput({n, " taken"}, 32'(o_taken[d]), 32'(e_taken));
        checkOutput({n, " ip_out"}, 32'(o_ip[d]), 32'(e_ip));
        checkOutput({n, " done cycle"}, 32'(done_cyc[d]), 32'(expDone(delay, e_taken)));
        checkOutput({n, " done pulses"}, 32'(done_cnt[d]), 32'd1);
        checkOutput({n, " busy cycles"}, 32'(busy_cnt[d]), 32'(expDone(delay, e_taken)));
        checkOutput({n, " m1 cycles"}, 32'(m1_cnt[d]), TCYC ? 32'd1 : 32'd0);
        checkOutput({n, " rd cycles"}, 32'(rd_cnt[d]), 32'(rdLen(delay)));
        checkOutput({n, " int cycles"}, 32'(int_cnt[d]), e_taken ? (TCYC ? 32'd5 : 32'd1) : 32'd0);
        checkOutput({n, " rd_req cycles"}, 32'(req_cnt[d]), 32'(delay + 1));
    endtask

    task automatic checkResetState(input string tag);
        for (int d = 0; d < 3; d++) begin
            checkOutput($sformatf("%s dut%0d busy", tag, d), 32'(o_busy[d]), 32'd0);
            checkOutput($sformatf("%s dut%0d rd_req", tag, d), 32'(o_req[d]), 32'd0);
            checkOutput($sformatf("%s dut%0d done", tag, d), 32'(o_done[d]), 32'd0);
            checkOutput($sformatf("%s dut%0d taken", tag, d), 32'(o_taken[d]), 32'd0);
            checkOutput($sformatf("%s dut%0d mcycle", tag, d), 32'(o_mc[d]), 32'd0);
            checkOutput($sformatf("%s dut%0d rd_addr", tag, d), 32'(o_addr[d]), 32'd0);
            checkOutput($sformatf("%s dut%0d ip_out", tag, d), 32'(o_ip[d]), 32'd0);
            checkOutput($sformatf("%s dut%0d cnt_out", tag, d), 32'(o_cnt[d]), 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] r_ip;
        logic [15:0] r_cnt;
        logic        r_cnd;
        logic [7:0]  r_data;
        int          r_delay;
        logic [15:0] e_addr;
        logic [15:0] e_cnt;
        logic        e_taken;
        logic [15:0] e_ip;
        int          sel;

        vecs[0] = '{0, 16'h1000, 16'h0005, 1'b1, 8'hFE, 0, 16'h1001, 16'h0004, 1'b1, 16'h1000, 10, 3};
        vecs[1] = '{0, 16'h1000, 16'h0001, 1'b1, 8'hFE, 0, 16'h1001, 16'h0000, 1'b0, 16'h1002, 5, 2};
        vecs[2] = '{1, 16'hFFFF, 16'h0000, 1'b1, 8'h7F, 0, 16'h0000, 16'hFFFF, 1'b1, 16'h0080, 10, 3};
        vecs[3] = '{2, 16'h2000, 16'h0009, 1'b0, 8'h55, 4, 16'h2002, 16'h0008, 1'b0, 16'h2003, 7, 6};
        vecs[4] = '{0, 16'h0010, 16'h0000, 1'b1, 8'h80, 0, 16'h0011, 16'h00FF, 1'b1, 16'hFF92, 10, 3};
        vecs[5] = '{2, 16'hFFFE, 16'h0002, 1'b1, 8'h01, 1, 16'h0000, 16'h0001, 1'b1, 16'h0002, 10, 4};

        reset   = 1'b1;
        start   = 1'b0;
        ip_in   = 16'h0000;
        cnt_in  = 16'h0000;
        cond_in = 1'b0;
        rd_ack  = 1'b0;
        rd_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkResetState("after reset");

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].ip, vecs[i].cnt, vecs[i].cnd, vecs[i].data, vecs[i].delay,
                          $sformatf("vec%0d", i));
            sel = vecs[i].dut;
            checkOutput($sformatf("vec%0d const rd_addr", i), 32'(o_addr[sel]), 32'(vecs[i].e_addr));
            checkOutput($sformatf("vec%0d const cnt_out", i), 32'(o_cnt[sel]), 32'(vecs[i].e_cnt));
            checkOutput($sformatf("vec%0d const taken", i), 32'(o_taken[sel]), 32'(vecs[i].e_taken));
            checkOutput($sformatf("vec%0d const ip_out", i), 32'(o_ip[sel]), 32'(vecs[i].e_ip));
            checkOutput($sformatf("vec%0d const done cycle", i), 32'(done_cyc[sel]),
                        32'(TCYC ? vecs[i].e_done_on : vecs[i].e_done_off));
            for (int d = 0; d < 3; d++) begin
                checkModel(d, vecs[i].ip, vecs[i].cnt, vecs[i].cnd, vecs[i].data, vecs[i].delay,
                           $sformatf("vec%0d", i));
            end
        end

        for (int i = 0; i < 40; i++) begin
            r_ip    = 16'($urandom);
            r_cnt   = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 2)) : 16'($urandom);
            r_cnd   = ($urandom_range(0, 3) != 0);
            r_data  = 8'($urandom);
            r_delay = $urandom_range(0, 5);
            applyStimulus(r_ip, r_cnt, r_cnd, r_data, r_delay, $sformatf("rand%0d", i));
            for (int d = 0; d < 3; d++) begin
                checkModel(d, r_ip, r_cnt, r_cnd, r_data, r_delay, $sformatf("rand%0d", i));
            end
        end

        // Abort in RD: read never acknowledged, stray start while busy, then reset.
        @(posedge clk);
        #1;
        start   = 1'b1;
        ip_in   = 16'h3000;
        cnt_in  = 16'h0005;
        cond_in = 1'b1;
        rd_ack  = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (o_mc[0] == 2'd2) break;
        end
        checkOutput("abort reached RD", 32'(o_mc[0]), 32'd2);
        @(posedge clk);
        #1;
        start  = 1'b1;
        ip_in  = 16'h4444;
        cnt_in = 16'h0001;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            model(DUT_CW[d], DUT_IL[d], 16'h3000, 16'h0005, 1'b1, 8'h00, e_addr, e_cnt, e_taken, e_ip);
            checkOutput($sformatf("stray start dut%0d busy", d), 32'(o_busy[d]), 32'd1);
            checkOutput($sformatf("stray start dut%0d rd_req", d), 32'(o_req[d]), 32'd1);
            checkOutput($sformatf("stray start dut%0d rd_addr", d), 32'(o_addr[d]), 32'(e_addr));
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkResetState("abort in RD");

        // Reset and start together: reset wins, no operation starts.
        @(posedge clk);
        #1;
        reset   = 1'b1;
        start   = 1'b1;
        ip_in   = 16'h5555;
        cnt_in  = 16'h0003;
        @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checkOutput($sformatf("reset+start dut%0d busy", d), 32'(o_busy[d]), 32'd0);
            checkOutput($sformatf("reset+start dut%0d rd_addr", d), 32'(o_addr[d]), 32'd0);
        end

        // Unit must still work normally after the abort.
        applyStimulus(16'h1000, 16'h0005, 1'b1, 8'hFE, 0, "post-abort");
        for (int d = 0; d < 3; d++) begin
            checkModel(d, 16'h1000, 16'h0005, 1'b1, 8'hFE, 0, "post-abort");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
